pdatapath_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit MIPS datapath. Replaces direct pushbutton clocking of PC, register file and data memory: everything runs on the board clock, and this block issues one-cycle enable strobes per instruction phase. Supports single-step, free-run, a PC breakpoint and a HALT opcode. Sits beside the instruction decoder; its strobes gate instruction memory, the PC, register file write and data memory write.

---
 rtl/pdatapath_sequencer_pkg.sv | 21 ++
 rtl/pdatapath_sequencer_step_edge.sv | 38 +++
 rtl/pdatapath_sequencer.sv | 159 +++++++++++++++
 tb/tb_pdatapath_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdatapath_sequencer_pkg.sv
// Shared definitions for the multi-cycle datapath sequencer: state encoding
// (visible on the state port for VIO) and default constants.
package pdatapath_sequencer_pkg;

   // Instruction phase encoding, fixed so external debug tools can decode it.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } seq_state_t;

   // Opcode that parks the machine in HALT until reset.
   localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

   // Width of the EXECUTE settling counter (supports 0..15 extra cycles).
   localparam int WAIT_W = 4;

endpackage

// File: rtl/pdatapath_sequencer_step_edge.sv
// Step button edge detector with a one-deep pending request flag.
// An edge seen while the sequencer is busy is remembered once; further
// edges before it is consumed are dropped.
module pdatapath_sequencer_step_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_step,
   input  logic i_in_idle,
   input  logic i_consume,
   input  logic i_clear,
   output logic o_edge,
   output logic o_pending
);

   logic r_step_q;
   logic r_pending;

   assign o_edge    = i_step & ~r_step_q;
   assign o_pending = r_pending;

   // Track the previous button level; reset loads the live level so a
   // button held through reset does not count as a press.
   always_ff @(posedge i_clk) begin
      r_step_q <= i_step;
   end

   // Pending flag: set by an edge outside IDLE, cleared on consume or HALT.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_pending <= 1'b0;
      end else if (i_consume) begin
         r_pending <= 1'b0;
      end else if (o_edge && !i_in_idle) begin
         r_pending <= 1'b1;
      end
   end

endmodule

// File: rtl/pdatapath_sequencer.sv
// Multi-cycle control sequencer for the 8-bit MIPS datapath. Issues one-cycle
// enable strobes per instruction phase on the board clock; supports
// single-step, free-run, a PC breakpoint and a HALT opcode.
// Handshake: there is no valid/ready pair; every strobe is a single-cycle
// registered pulse that the datapath must act on in the cycle it is high.
module pdatapath_sequencer
   import pdatapath_sequencer_pkg::*;
#(
   parameter int         PC_W        = 8,
   parameter int         CNT_W       = 16,
   parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
   parameter int         EXEC_WAIT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_in,
   input  logic             run_in,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   input  logic [3:0]       opcode,
   input  logic             reg_write_in,
   input  logic             mem_write_in,
   output logic             imem_en,
   output logic             pc_inc,
   output logic             rf_wr_en,
   output logic             dmem_we,
   output logic [2:0]       state,
   output logic             busy,
   output logic             halted,
   output logic             bp_hit,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EXEC_WAIT);

   seq_state_t        r_state;
   logic [WAIT_W-1:0] r_wait;
   logic [CNT_W-1:0]  r_instr_count;
   logic              r_imem_en;
   logic              r_pc_inc;
   logic              r_rf_wr_en;
   logic              r_dmem_we;
   logic              r_busy;
   logic              r_halted;
   logic              r_bp_hit;

   logic w_in_idle;
   logic w_step_edge;
   logic w_step_pending;
   logic w_step_go;
   logic w_in_halt;

   assign w_in_idle = (r_state == S_IDLE);
   assign w_in_halt = (r_state == S_HALT);
   assign w_step_go = w_in_idle & (w_step_edge | w_step_pending);

   pdatapath_sequencer_step_edge u_step_edge (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_step    (step_in),
      .i_in_idle (w_in_idle),
      .i_consume (w_step_go),
      .i_clear   (w_in_halt),
      .o_edge    (w_step_edge),
      .o_pending (w_step_pending)
   );

   // Phase FSM with registered strobes, wait counter and retired counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wait        <= '0;
         r_instr_count <= '0;
         r_imem_en     <= 1'b0;
         r_pc_inc      <= 1'b0;
         r_rf_wr_en    <= 1'b0;
         r_dmem_we     <= 1'b0;
         r_busy        <= 1'b0;
         r_halted      <= 1'b0;
         r_bp_hit      <= 1'b0;
      end else begin
         r_imem_en  <= 1'b0;
         r_pc_inc   <= 1'b0;
         r_rf_wr_en <= 1'b0;
         r_dmem_we  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A step always wins over run and releases a breakpoint stop.
               if (w_step_go) begin
                  r_state   <= S_FETCH;
                  r_imem_en <= 1'b1;
                  r_busy    <= 1'b1;
                  r_bp_hit  <= 1'b0;
               end else if (run_in && !r_bp_hit) begin
                  if (bp_en && (pc == bp_addr)) begin
                     r_bp_hit <= 1'b1;
                  end else begin
                     r_state   <= S_FETCH;
                     r_imem_en <= 1'b1;
                     r_busy    <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               // BRAM read in flight; instruction word valid next cycle.
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               if (opcode == HALT_OPCODE) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= S_EXECUTE;
                  r_wait  <= WAIT_LOAD;
               end
            end
            S_EXECUTE: begin
               // Decoder outputs are stable since DECODE, so the write
               // strobes can be captured here for the WRITEBACK cycle.
               if (r_wait != '0) begin
                  r_wait <= r_wait - 1'b1;
               end else begin
                  r_state    <= S_WRITEBACK;
                  r_pc_inc   <= 1'b1;
                  r_rf_wr_en <= reg_write_in;
                  r_dmem_we  <= mem_write_in;
               end
            end
            S_WRITEBACK: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (r_instr_count != {CNT_W{1'b1}}) begin
                  r_instr_count <= r_instr_count + 1'b1;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_en     = r_imem_en;
   assign pc_inc      = r_pc_inc;
   assign rf_wr_en    = r_rf_wr_en;
   assign dmem_we     = r_dmem_we;
   assign state       = r_state;
   assign busy        = r_busy;
   assign halted      = r_halted;
   assign bp_hit      = r_bp_hit;
   assign instr_count = r_instr_count;

endmodule

// File: tb/tb_pdatapath_sequencer.sv
// Bench for pdatapath_sequencer: a small PC/program model feeds the decoder
// inputs, expected retirements are queued when stimulus is issued and a
// monitor checks each WRITEBACK strobe against the queue.
module tb_pdatapath_sequencer;

   localparam int EW  = 2;        // extra EXECUTE cycles
   localparam int LAT = 4 + EW;   // IDLE decision cycle -> WRITEBACK cycle
   localparam int CPI = 5 + EW;   // free-run cycles per instruction
   localparam int QW  = 58;       // {cycle, pc, rf, dm, count-before}

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step_in = 1'b0;
   logic        run_in = 1'b0;
   logic        bp_en = 1'b0;
   logic [7:0]  bp_addr = 8'h00;
   logic [7:0]  pc = 8'h00;
   logic [3:0]  opcode = 4'h0;
   logic        reg_write_in = 1'b0;
   logic        mem_write_in = 1'b0;
   logic        imem_en;
   logic        pc_inc;
   logic        rf_wr_en;
   logic        dmem_we;
   logic [2:0]  state;
   logic        busy;
   logic        halted;
   logic        bp_hit;
   logic [15:0] instr_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [QW-1:0] exp_q[$];
   logic [3:0]    prog_op[256];
   logic          prog_rw[256];
   logic          prog_mw[256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pdatapath_sequencer #(
      .PC_W(8), .CNT_W(16), .HALT_OPCODE(4'hF), .EXEC_WAIT(EW)
   ) dut (
      .clk(clk), .rst(rst), .step_in(step_in), .run_in(run_in),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .opcode(opcode),
      .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
      .imem_en(imem_en), .pc_inc(pc_inc), .rf_wr_en(rf_wr_en),
      .dmem_we(dmem_we), .state(state), .busy(busy), .halted(halted),
      .bp_hit(bp_hit), .instr_count(instr_count)
   );

   // ---------------- datapath model: PC register + decoder ----------------
   initial begin
      logic adv;
      logic rs;
      forever begin
         @(negedge clk);
         adv = pc_inc;
         rs  = rst;
         @(posedge clk);
         #1;
         if (rs) pc = 8'h00;
         else if (adv) pc = pc + 8'h01;
         opcode       = prog_op[pc];
         reg_write_in = prog_rw[pc];
         mem_write_in = prog_mw[pc];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 256; i++) begin
         prog_op[i] = 4'($urandom_range(0, 14));
         prog_rw[i] = 1'($urandom_range(0, 1));
         prog_mw[i] = 1'($urandom_range(0, 1));
      end
   endtask

   // Expected retirement of the instruction at PC p in cycle c, with the
   // counter still showing the number retired before it.
   task automatic expect_retire(input int c, input int p, input int cnt);
      logic [QW-1:0] e;
      e = {c[31:0], p[7:0], prog_rw[p], prog_mw[p], cnt[15:0]};
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      step_in = 1'b0;
      run_in = 1'b0;
      bp_en = 1'b0;
      tick(3);
      check({tag, "_rst_flags"},
            {24'h0, state, busy, halted, bp_hit, imem_en, pc_inc}, 32'h0);
      check({tag, "_rst_wr"}, {30'h0, rf_wr_en, dmem_we}, 32'h0);
      check({tag, "_rst_count"}, 32'(instr_count), 32'h0);
      rst = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [QW-1:0] e;
      logic [QW-1:0] act;
      forever begin
         @(negedge clk);
         if (imem_en || pc_inc) check("strobe_exclusive", 32'(imem_en & pc_inc), 32'h0);
         if (rf_wr_en || dmem_we) check("write_outside_wb", 32'(pc_inc), 32'h1);
         if (pc_inc) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_retire: cycle %0d pc %0h count %0d, none expected",
                        cyc, pc, instr_count);
            end else begin
               e   = exp_q.pop_front();
               act = {cyc[31:0], pc, rf_wr_en, dmem_we, instr_count};
               if (act !== e) begin
                  bad++;
                  $display("FAIL retire: got cyc=%0d pc=%0h rf=%0b dm=%0b cnt=%0d expected cyc=%0d pc=%0h rf=%0b dm=%0b cnt=%0d",
                           act[57:26], act[25:18], act[17], act[16], act[15:0],
                           e[57:26], e[25:18], e[17], e[16], e[15:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      int s;
      int n;
      int b;

      // 1: single step of an ADD with RegWrite; held button must not repeat
      load_prog();
      prog_op[0] = 4'h0; prog_rw[0] = 1'b1; prog_mw[0] = 1'b0;
      do_reset("s1");
      tick(2);
      t = cyc;
      step_in = 1'b1;
      expect_retire(t + LAT, 0, 0);
      tick(1);
      check("s1_fetch_imem", 32'(imem_en), 32'h1);
      check("s1_fetch_state", 32'(state), 32'd1);
      check("s1_fetch_busy", 32'(busy), 32'h1);
      tick(1);
      check("s1_decode_imem", 32'(imem_en), 32'h0);
      check("s1_decode_state", 32'(state), 32'd2);
      tick(LAT - 2);
      check("s1_wb_state", 32'(state), 32'd4);
      tick(1);
      check("s1_after_count", 32'(instr_count), 32'd1);
      check("s1_after_state", 32'(state), 32'd0);
      check("s1_after_busy", 32'(busy), 32'h0);
      tick(15);
      check("s1_held_count", 32'(instr_count), 32'd1);
      check("s1_held_pc", 32'(pc), 32'd1);
      check("s1_queue_empty", 32'(exp_q.size()), 32'd0);
      step_in = 1'b0;

      // 2: free-run a random number of random instructions, one is a SW
      load_prog();
      prog_op[1] = 4'hB; prog_rw[1] = 1'b0; prog_mw[1] = 1'b1;
      n = $urandom_range(3, 5);
      do_reset("s2");
      tick(1);
      t = cyc;
      run_in = 1'b1;
      for (int k = 0; k < n; k++) expect_retire(t + LAT + k * CPI, k, k);
      tick(CPI * (n - 1) + 2);
      run_in = 1'b0;
      tick(LAT + CPI + 5);
      check("s2_count", 32'(instr_count), 32'(n));
      check("s2_pc", 32'(pc), 32'(n));
      check("s2_idle", 32'(state), 32'd0);
      check("s2_queue_empty", 32'(exp_q.size()), 32'd0);

      // 3: breakpoint stop, step through it, resume run
      load_prog();
      b = $urandom_range(2, 4);
      do_reset("s3");
      bp_en = 1'b1;
      bp_addr = 8'(b);
      tick(1);
      t = cyc;
      run_in = 1'b1;
      for (int k = 0; k < b; k++) expect_retire(t + LAT + k * CPI, k, k);
      tick(b * CPI + 6);
      check("s3_bp_hit", 32'(bp_hit), 32'h1);
      check("s3_bp_state", 32'(state), 32'd0);
      check("s3_bp_pc", 32'(pc), 32'(b));
      check("s3_bp_count", 32'(instr_count), 32'(b));
      check("s3_bp_queue", 32'(exp_q.size()), 32'd0);
      s = cyc;
      step_in = 1'b1;
      expect_retire(s + LAT, b, b);
      expect_retire(s + LAT + CPI, b + 1, b + 1);
      tick(1);
      step_in = 1'b0;
      check("s3_step_clears_bp", 32'(bp_hit), 32'h0);
      tick(CPI + 1);
      run_in = 1'b0;
      tick(LAT + CPI + 4);
      check("s3_resume_count", 32'(instr_count), 32'(b + 2));
      check("s3_resume_pc", 32'(pc), 32'(b + 2));
      check("s3_resume_queue", 32'(exp_q.size()), 32'd0);
      bp_en = 1'b0;

      // 4: step presses during EXECUTE: one is queued, the second dropped
      load_prog();
      do_reset("s4");
      tick(1);
      t = cyc;
      step_in = 1'b1;
      expect_retire(t + LAT, 0, 0);
      expect_retire(t + LAT + CPI, 1, 1);
      tick(1); step_in = 1'b0;
      tick(2); step_in = 1'b1;
      tick(1); step_in = 1'b0;
      tick(1); step_in = 1'b1;
      tick(1); step_in = 1'b0;
      tick(LAT + CPI + 10);
      check("s4_count", 32'(instr_count), 32'd2);
      check("s4_idle", 32'(state), 32'd0);
      check("s4_queue_empty", 32'(exp_q.size()), 32'd0);

      // 5: HALT opcode stops the machine until reset
      load_prog();
      prog_op[1] = 4'hF;
      do_reset("s5");
      tick(1);
      t = cyc;
      run_in = 1'b1;
      expect_retire(t + LAT, 0, 0);
      tick(CPI + 3);
      check("s5_halt_state", 32'(state), 32'd5);
      check("s5_halted", 32'(halted), 32'h1);
      check("s5_busy", 32'(busy), 32'h0);
      check("s5_count", 32'(instr_count), 32'd1);
      for (int k = 0; k < 2; k++) begin
         step_in = 1'b1; tick(2);
         step_in = 1'b0; tick(2);
      end
      tick(10);
      check("s5_still_halted", 32'(state), 32'd5);
      check("s5_still_count", 32'(instr_count), 32'd1);
      check("s5_still_pc", 32'(pc), 32'd1);
      check("s5_queue_empty", 32'(exp_q.size()), 32'd0);
      do_reset("s5b");

      // 6: reset asserted during WRITEBACK
      load_prog();
      do_reset("s6");
      tick(1);
      t = cyc;
      step_in = 1'b1;
      expect_retire(t + LAT, 0, 0);
      tick(1); step_in = 1'b0;
      tick(LAT - 1);
      check("s6_wb_state", 32'(state), 32'd4);
      rst = 1'b1;
      tick(1);
      check("s6_rst_flags",
            {24'h0, state, busy, halted, bp_hit, imem_en, pc_inc}, 32'h0);
      check("s6_rst_wr", {30'h0, rf_wr_en, dmem_we}, 32'h0);
      check("s6_rst_count", 32'(instr_count), 32'h0);
      rst = 1'b0;
      tick(3);
      check("s6_idle", 32'(state), 32'd0);
      check("s6_pc", 32'(pc), 32'd0);
      check("s6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
